fir_complex: RTL and testbench

Complex-input, complex-coefficient 20-tap FIR used as the FM receiver's channel filter, between the I/Q sample reader and the FM demodulator. It accepts one I/Q sample pair per input-FIFO write and produces one filtered I/Q pair per input pair, with no decimation. Samples are 32-bit signed fixed point with 10 fractional bits (Q10). Input and output are buffered by FIFOs on both the real and imaginary paths.

---
 rtl/fir_pkg.sv | 46 ++++
 rtl/fifo.sv | 78 +++++++
 rtl/fir_complex.sv | 185 ++++++++++++++++++
 tb/tb_fir_complex.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the complex channel FIR.
// Holds the sample width, tap count, Q10 fraction width, the Q10 tap tables and
// the DQ rescale helper used by the MAC datapath.
package fir_pkg;

    localparam int unsigned DATA_SIZE = 32;
    localparam int unsigned TAPS      = 20;
    localparam int unsigned BITS      = 10;
    localparam int unsigned PROD_W    = 2 * DATA_SIZE;

    typedef logic signed [DATA_SIZE-1:0] sample_t;
    typedef logic signed [PROD_W-1:0]    prod_t;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StWrite
    } state_e;

    localparam sample_t COEFFS_REAL [TAPS] = '{
        32'h00000001, 32'h00000008, 32'hFFFFFFF3, 32'h00000009, 32'h0000000B,
        32'hFFFFFFD3, 32'h00000045, 32'hFFFFFFD3, 32'hFFFFFFB1, 32'h00000257,
        32'h00000257, 32'hFFFFFFB1, 32'hFFFFFFD3, 32'h00000045, 32'hFFFFFFD3,
        32'h0000000B, 32'h00000009, 32'hFFFFFFF3, 32'h00000008, 32'h00000001
    };

    localparam sample_t COEFFS_IMAG [TAPS] = '{default: '0};

    // Sign-extend a sample to product width so the multiply is full precision.
    function automatic prod_t sext(input sample_t a);
        return prod_t'(a);
    endfunction

    // Divide by 2^BITS truncating toward zero: bias negatives before the
    // arithmetic shift so the shift does not round toward minus infinity.
    function automatic sample_t dq(input prod_t v);
        prod_t t;
        t = v;
        if (v[PROD_W-1]) begin
            t = v + prod_t'((1 << BITS) - 1);
        end
        t = t >>> BITS;
        return t[DATA_SIZE-1:0];
    endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk_i   - rising-edge clock
//   rst_i   - async active-high reset, flushes contents and zeroes storage
//   wr_en_i - push din_i (ignored while full)
//   din_i   - write data
//   full_o  - no free entries
//   rd_en_i - pop head entry (ignored while empty)
//   dout_o  - head entry, valid whenever empty_o is low
//   empty_o - no stored entries
module fifo #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [DATA_SIZE-1:0] din_i,
    output logic                 full_o,
    input  logic                 rd_en_i,
    output logic [DATA_SIZE-1:0] dout_o,
    output logic                 empty_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 wr_ok, rd_ok;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // Requests against a full/empty FIFO are dropped here, so a simultaneous
    // read+write at either boundary only performs the legal half.
    assign wr_ok = wr_en_i && !full_o;
    assign rd_ok = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

endmodule

// File: rtl/fir_complex.sv
// Complex-input, complex-coefficient FIR channel filter (Q10, no decimation).
// Each I/Q pair popped from the input FIFOs is shifted into the sample buffer,
// filtered one tap per clock, and the result pair pushed to the output FIFOs.
// Ports:
//   clock, reset                    - rising-edge clock, async active-high reset
//   xreal_in_* / ximag_in_*         - input FIFO write side (din, wr_en, full)
//   yreal_out_* / yimag_out_*       - show-ahead output FIFO read side (dout, rd_en, empty)
module fir_complex
    import fir_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] xreal_in_din,
    input  logic                 xreal_in_wr_en,
    output logic                 xreal_in_full,
    input  logic [DATA_SIZE-1:0] ximag_in_din,
    input  logic                 ximag_in_wr_en,
    output logic                 ximag_in_full,
    output logic [DATA_SIZE-1:0] yreal_out_dout,
    input  logic                 yreal_out_rd_en,
    output logic                 yreal_out_empty,
    output logic [DATA_SIZE-1:0] yimag_out_dout,
    input  logic                 yimag_out_rd_en,
    output logic                 yimag_out_empty
);

    localparam int unsigned TAP_W = $clog2(TAPS);

    logic [DATA_SIZE-1:0] xr_dout, xi_dout;
    logic                 xr_empty, xi_empty;
    logic                 yr_full, yi_full;
    logic                 pop, push;

    state_e           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    sample_t          acc_r_q, acc_r_d;
    sample_t          acc_i_q, acc_i_d;
    sample_t          xr_q [TAPS];
    sample_t          xi_q [TAPS];

    sample_t hr_j, hi_j, xr_j, xi_j;
    prod_t   p_rr, p_ii, p_ri, p_ir;
    sample_t term_r, term_i;

    fifo #(
        .DATA_SIZE (DATA_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_xreal_fifo (
        .clk_i  (clock),
        .rst_i  (reset),
        .wr_en_i(xreal_in_wr_en),
        .din_i  (xreal_in_din),
        .full_o (xreal_in_full),
        .rd_en_i(pop),
        .dout_o (xr_dout),
        .empty_o(xr_empty)
    );

    fifo #(
        .DATA_SIZE (DATA_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_ximag_fifo (
        .clk_i  (clock),
        .rst_i  (reset),
        .wr_en_i(ximag_in_wr_en),
        .din_i  (ximag_in_din),
        .full_o (ximag_in_full),
        .rd_en_i(pop),
        .dout_o (xi_dout),
        .empty_o(xi_empty)
    );

    fifo #(
        .DATA_SIZE (DATA_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_yreal_fifo (
        .clk_i  (clock),
        .rst_i  (reset),
        .wr_en_i(push),
        .din_i  (acc_r_q),
        .full_o (yr_full),
        .rd_en_i(yreal_out_rd_en),
        .dout_o (yreal_out_dout),
        .empty_o(yreal_out_empty)
    );

    fifo #(
        .DATA_SIZE (DATA_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_yimag_fifo (
        .clk_i  (clock),
        .rst_i  (reset),
        .wr_en_i(push),
        .din_i  (acc_i_q),
        .full_o (yi_full),
        .rd_en_i(yimag_out_rd_en),
        .dout_o (yimag_out_dout),
        .empty_o(yimag_out_empty)
    );

    // One complex tap product per cycle, rescaled per term before accumulating.
    always_comb begin
        hr_j   = COEFFS_REAL[tap_q];
        hi_j   = COEFFS_IMAG[tap_q];
        xr_j   = xr_q[tap_q];
        xi_j   = xi_q[tap_q];
        p_rr   = sext(hr_j) * sext(xr_j);
        p_ii   = sext(hi_j) * sext(xi_j);
        p_ri   = sext(hr_j) * sext(xi_j);
        p_ir   = sext(hi_j) * sext(xr_j);
        term_r = dq(p_rr - p_ii);
        term_i = dq(p_ri + p_ir);
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        acc_r_d = acc_r_q;
        acc_i_d = acc_i_q;
        pop     = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Both paths pop together so I and Q never drift apart.
                if (!xr_empty && !xi_empty) begin
                    pop     = 1'b1;
                    tap_d   = '0;
                    acc_r_d = '0;
                    acc_i_d = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_r_d = acc_r_q + term_r;
                acc_i_d = acc_i_q + term_i;
                if (tap_q == TAP_W'(TAPS - 1)) begin
                    state_d = StWrite;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            StWrite: begin
                if (!yr_full && !yi_full) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tap_q   <= '0;
            acc_r_q <= '0;
            acc_i_q <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            acc_r_q <= acc_r_d;
            acc_i_q <= acc_i_d;
        end
    end

    // Sample delay line: newest pair at index 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                xr_q[i] <= '0;
                xi_q[i] <= '0;
            end
        end else if (pop) begin
            xr_q[0] <= xr_dout;
            xi_q[0] <= xi_dout;
            for (int i = 1; i < int'(TAPS); i++) begin
                xr_q[i] <= xr_q[i-1];
                xi_q[i] <= xi_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fir_complex.sv
// Directed self-checking bench for fir_complex.
module tb_fir_complex;

    localparam int TAPS = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] xreal_in_din, ximag_in_din;
    logic        xreal_in_wr_en, ximag_in_wr_en;
    logic        xreal_in_full, ximag_in_full;
    logic [31:0] yreal_out_dout, yimag_out_dout;
    logic        yreal_out_rd_en, yimag_out_rd_en;
    logic        yreal_out_empty, yimag_out_empty;

    always #5 clock = ~clock;

    fir_complex #(
        .FIFO_DEPTH(16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .xreal_in_din   (xreal_in_din),
        .xreal_in_wr_en (xreal_in_wr_en),
        .xreal_in_full  (xreal_in_full),
        .ximag_in_din   (ximag_in_din),
        .ximag_in_wr_en (ximag_in_wr_en),
        .ximag_in_full  (ximag_in_full),
        .yreal_out_dout (yreal_out_dout),
        .yreal_out_rd_en(yreal_out_rd_en),
        .yreal_out_empty(yreal_out_empty),
        .yimag_out_dout (yimag_out_dout),
        .yimag_out_rd_en(yimag_out_rd_en),
        .yimag_out_empty(yimag_out_empty)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Channel taps as plain integers (Q10).
    int h [TAPS] = '{1, 8, -13, 9, 11, -45, 69, -45, -79, 599,
                     599, -79, -45, 69, -45, 11, 9, -13, 8, 1};

    logic [31:0] in_r  [64];
    logic [31:0] in_i  [64];
    logic [31:0] exp_r [64];
    logic [31:0] exp_i [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %h, want %h", tag, obs, expv);
    endtask

    // Impulse at sample 0 then zeros; expected outputs are scaled tap tables.
    task automatic load_impulse(input logic [31:0] xr0, input logic [31:0] xi0,
                                input int sr, input int si);
        for (int k = 0; k < TAPS; k++) begin
            in_r[k]  = (k == 0) ? xr0 : 32'h0;
            in_i[k]  = (k == 0) ? xi0 : 32'h0;
            exp_r[k] = 32'(sr * h[k]);
            exp_i[k] = 32'(si * h[k]);
        end
    endtask

    // Push up to n_in pairs and pop/compare n_out pairs, one of each per cycle.
    task automatic run(input string name, input int n_in, input int n_out, input int max_cyc,
                       output int pushed, output int popped);
        pushed = 0;
        popped = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clock);
            if (n_out > 0 && popped < n_out && !yreal_out_empty) begin
                check($sformatf("%s empty_pair[%0d]", name, popped),
                      32'(yimag_out_empty), 32'(yreal_out_empty));
                check($sformatf("%s yr[%0d]", name, popped), yreal_out_dout, exp_r[popped]);
                check($sformatf("%s yi[%0d]", name, popped), yimag_out_dout, exp_i[popped]);
                yreal_out_rd_en = 1'b1;
                yimag_out_rd_en = 1'b1;
                popped++;
            end else begin
                yreal_out_rd_en = 1'b0;
                yimag_out_rd_en = 1'b0;
            end
            // wr_en stays high even when full to exercise the drop-on-full path.
            if (pushed < n_in) begin
                xreal_in_din   = in_r[pushed];
                ximag_in_din   = in_i[pushed];
                xreal_in_wr_en = 1'b1;
                ximag_in_wr_en = 1'b1;
                if (!xreal_in_full && !ximag_in_full) pushed++;
            end else begin
                xreal_in_wr_en = 1'b0;
                ximag_in_wr_en = 1'b0;
            end
            if (n_out > 0 && popped == n_out && pushed == n_in) break;
        end
        @(negedge clock);
        xreal_in_wr_en  = 1'b0;
        ximag_in_wr_en  = 1'b0;
        yreal_out_rd_en = 1'b0;
        yimag_out_rd_en = 1'b0;
    endtask

    task automatic check_idle_flags(input string name);
        check({name, " xr_full"}, 32'(xreal_in_full), 32'd0);
        check({name, " xi_full"}, 32'(ximag_in_full), 32'd0);
        check({name, " yr_empty"}, 32'(yreal_out_empty), 32'd1);
        check({name, " yi_empty"}, 32'(yimag_out_empty), 32'd1);
        check({name, " yr_dout"}, yreal_out_dout, 32'd0);
        check({name, " yi_dout"}, yimag_out_dout, 32'd0);
    endtask

    initial begin
        int p, q, cyc, acc_r, acc_i;

        reset           = 1'b1;
        xreal_in_din    = '0;
        ximag_in_din    = '0;
        xreal_in_wr_en  = 1'b0;
        ximag_in_wr_en  = 1'b0;
        yreal_out_rd_en = 1'b0;
        yimag_out_rd_en = 1'b0;
        repeat (2) @(negedge clock);
        check_idle_flags("reset");
        reset = 1'b0;
        @(negedge clock);

        // Real impulse 1.0 -> yr = taps, yi = 0.
        load_impulse(32'h0000_0400, 32'h0, 1, 0);
        run("real_imp", TAPS, TAPS, 1500, p, q);
        check("real_imp count", 32'(q), 32'(TAPS));

        // Imaginary impulse 1.0 -> yi = taps, yr = 0.
        load_impulse(32'h0, 32'h0000_0400, 0, 1);
        run("imag_imp", TAPS, TAPS, 1500, p, q);
        check("imag_imp count", 32'(q), 32'(TAPS));

        // xr = -1.0 and xi = 2.0 together -> yr = -taps, yi = 2*taps.
        load_impulse(32'hFFFF_FC00, 32'h0000_0800, -1, 2);
        run("mixed_imp", TAPS, TAPS, 1500, p, q);
        check("mixed_imp count", 32'(q), 32'(TAPS));

        // xr = -1 LSB, xi = +1 LSB: every term |h| < 1024 truncates to 0.
        load_impulse(32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        run("trunc", TAPS, TAPS, 1500, p, q);
        check("trunc count", 32'(q), 32'(TAPS));

        // Backpressure: ramp inputs (exact Q10 integers) with outputs blocked.
        for (int n = 0; n < 40; n++) begin
            in_r[n] = 32'((n + 1) * 1024);
            in_i[n] = 32'(((n % 5) - 2) * 1024);
            acc_r = 0;
            acc_i = 0;
            for (int j = 0; j < TAPS; j++) begin
                if (n - j >= 0) begin
                    acc_r += h[j] * (n - j + 1);
                    acc_i += h[j] * (((n - j) % 5) - 2);
                end
            end
            exp_r[n] = 32'(acc_r);
            exp_i[n] = 32'(acc_i);
        end
        run("bp_fill", 40, 0, 900, p, q);
        // 16 in each output FIFO, 1 held in WRITE, 16 waiting in the inputs.
        check("bp accepted", 32'(p), 32'd33);
        check("bp xr_full", 32'(xreal_in_full), 32'd1);
        check("bp xi_full", 32'(ximag_in_full), 32'd1);
        check("bp yr_empty", 32'(yreal_out_empty), 32'd0);
        run("bp_drain", 0, 33, 1500, p, q);
        check("bp drained", 32'(q), 32'd33);
        repeat (3) @(negedge clock);
        check("bp yr_empty_end", 32'(yreal_out_empty), 32'd1);
        check("bp yi_empty_end", 32'(yimag_out_empty), 32'd1);

        // Reset mid-stream with large samples in flight.
        for (int k = 0; k < TAPS; k++) begin
            in_r[k] = 32'((k + 1) * 32'h0001_0000);
            in_i[k] = 32'((k + 3) * 32'h0000_8000);
        end
        run("pre_reset", TAPS, 0, 60, p, q);
        reset = 1'b1;
        #1;
        check_idle_flags("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_idle_flags("post_reset");

        // Fresh impulse after reset: latency bound and a residue-free response.
        xreal_in_din   = 32'h0000_0400;
        ximag_in_din   = 32'h0;
        xreal_in_wr_en = 1'b1;
        ximag_in_wr_en = 1'b1;
        @(negedge clock);
        xreal_in_wr_en = 1'b0;
        ximag_in_wr_en = 1'b0;
        cyc = 0;
        while (yreal_out_empty && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check("latency_within_taps_plus_4", 32'(cyc <= TAPS + 4), 32'd1);
        check("post_reset yr[0]", yreal_out_dout, 32'(h[0]));
        check("post_reset yi[0]", yimag_out_dout, 32'd0);
        yreal_out_rd_en = 1'b1;
        yimag_out_rd_en = 1'b1;
        @(negedge clock);
        yreal_out_rd_en = 1'b0;
        yimag_out_rd_en = 1'b0;
        for (int k = 0; k < TAPS - 1; k++) begin
            in_r[k]  = 32'h0;
            in_i[k]  = 32'h0;
            exp_r[k] = 32'(h[k+1]);
            exp_i[k] = 32'h0;
        end
        run("post_reset_imp", TAPS - 1, TAPS - 1, 1500, p, q);
        check("post_reset count", 32'(q), 32'(TAPS - 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
